alu_rs_scheduler: RTL and testbench

//  Reservation station and issue scheduler for the calc-class ALU (LUI..SRAI, every type the IsCalc

---
 rtl/alu_rs_scheduler_pkg.sv | 24 ++
 rtl/alu_rs_scheduler_pick_lowest.sv | 24 ++
 rtl/alu_rs_scheduler.sv | 165 ++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared definitions for the calc-class ALU reservation station:
// instruction type codes, width constants and the calc-type classifier.
package alu_rs_scheduler_pkg;

  localparam int unsigned INST_TYPE_WIDTH = 6;
  localparam int unsigned ROB_TAG_WIDTH   = 4;

  // Calc-class types occupy the contiguous range TY_LUI..TY_SRAI.
  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    TY_NOP   = 6'd0,
    TY_LUI, TY_AUIPC,
    TY_ADD, TY_SUB, TY_SLL, TY_SLT, TY_SLTU, TY_XOR, TY_SRL, TY_SRA, TY_OR, TY_AND,
    TY_ADDI, TY_SLTI, TY_SLTIU, TY_XORI, TY_ORI, TY_ANDI, TY_SLLI, TY_SRLI, TY_SRAI,
    TY_JAL, TY_JALR,
    TY_BEQ, TY_BNE, TY_BLT, TY_BGE, TY_BLTU, TY_BGEU,
    TY_LB, TY_LH, TY_LW, TY_LBU, TY_LHU,
    TY_SB, TY_SH, TY_SW
  } inst_type_e;

  function automatic logic is_calc(input logic [INST_TYPE_WIDTH-1:0] t);
    return (t >= TY_LUI) && (t <= TY_SRAI);
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_pick_lowest.sv
// Find-first-set: index of the lowest asserted request bit plus an any flag.
module alu_rs_scheduler_pick_lowest #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         i_req,
  output logic                 o_any,
  output logic [$clog2(N)-1:0] o_idx
);

  // Scan upward, latching the first set bit.
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !w_found) begin
        w_found = 1'b1;
        o_idx   = $clog2(N)'(i);
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station and one-per-cycle issue scheduler for the shared calc ALU.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned TYPE_W  = INST_TYPE_WIDTH,
  parameter int unsigned TAG_W   = ROB_TAG_WIDTH,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  input  logic [TAG_W-1:0]  in_qj,
  input  logic [TAG_W-1:0]  in_qk,
  input  logic              in_qj_busy,
  input  logic              in_qk_busy,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              alu_valid,
  output logic [TYPE_W-1:0] alu_type,
  output logic [DATA_W-1:0] alu_vj,
  output logic [DATA_W-1:0] alu_vk,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_pc,
  output logic [TAG_W-1:0]  alu_tag
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] r_valid;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_qk_busy;
  logic [TYPE_W-1:0]  r_type [RS_SIZE];
  logic [DATA_W-1:0]  r_vj   [RS_SIZE];
  logic [DATA_W-1:0]  r_vk   [RS_SIZE];
  logic [TAG_W-1:0]   r_qj   [RS_SIZE];
  logic [TAG_W-1:0]   r_qk   [RS_SIZE];
  logic [DATA_W-1:0]  r_imm  [RS_SIZE];
  logic [DATA_W-1:0]  r_pc   [RS_SIZE];
  logic [TAG_W-1:0]   r_tag  [RS_SIZE];
  logic [CNT_W-1:0]   r_count;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_any;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_issue_any;
  logic [IDX_W-1:0]   w_issue_idx;
  logic               w_accept;
  logic               w_in_j_wake;
  logic               w_in_k_wake;

  // Entries eligible for issue: valid with both operands already captured.
  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_valid[i] & ~r_qj_busy[i] & ~r_qk_busy[i];
    end
  end

  alu_rs_scheduler_pick_lowest #(.N(RS_SIZE)) u_alloc (
    .i_req (~r_valid),
    .o_any (w_free_any),
    .o_idx (w_free_idx)
  );

  alu_rs_scheduler_pick_lowest #(.N(RS_SIZE)) u_select (
    .i_req (w_ready),
    .o_any (w_issue_any),
    .o_idx (w_issue_idx)
  );

  assign in_ready    = (r_count < CNT_W'(RS_SIZE));
  assign w_accept    = in_valid & in_ready & w_free_any & is_calc(in_type);
  assign w_in_j_wake = in_qj_busy & cdb_valid & (cdb_tag == in_qj);
  assign w_in_k_wake = in_qk_busy & cdb_valid & (cdb_tag == in_qk);

  // Entry table, issue register and occupancy count; reset > freeze > flush > normal.
  // Issue frees a valid slot while allocation targets an invalid one, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= '0;
      r_qj_busy <= '0;
      r_qk_busy <= '0;
      r_count   <= '0;
      alu_valid <= 1'b0;
      alu_type  <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_tag   <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        r_type[i] <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        r_valid   <= '0;
        r_count   <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (r_valid[i] && cdb_valid) begin
            if (r_qj_busy[i] && (r_qj[i] == cdb_tag)) begin
              r_vj[i]      <= cdb_value;
              r_qj_busy[i] <= 1'b0;
            end
            if (r_qk_busy[i] && (r_qk[i] == cdb_tag)) begin
              r_vk[i]      <= cdb_value;
              r_qk_busy[i] <= 1'b0;
            end
          end
        end

        alu_valid <= w_issue_any;
        if (w_issue_any) begin
          alu_type             <= r_type[w_issue_idx];
          alu_vj               <= r_vj[w_issue_idx];
          alu_vk               <= r_vk[w_issue_idx];
          alu_imm              <= r_imm[w_issue_idx];
          alu_pc               <= r_pc[w_issue_idx];
          alu_tag              <= r_tag[w_issue_idx];
          r_valid[w_issue_idx] <= 1'b0;
        end

        if (w_accept) begin
          r_valid[w_free_idx]   <= 1'b1;
          r_type[w_free_idx]    <= in_type;
          r_vj[w_free_idx]      <= w_in_j_wake ? cdb_value : in_vj;
          r_vk[w_free_idx]      <= w_in_k_wake ? cdb_value : in_vk;
          r_qj[w_free_idx]      <= in_qj;
          r_qk[w_free_idx]      <= in_qk;
          r_qj_busy[w_free_idx] <= in_qj_busy & ~w_in_j_wake;
          r_qk_busy[w_free_idx] <= in_qk_busy & ~w_in_k_wake;
          r_imm[w_free_idx]     <= in_imm;
          r_pc[w_free_idx]      <= in_pc;
          r_tag[w_free_idx]     <= in_tag;
        end

        if (w_accept && !w_issue_any) begin
          r_count <= r_count + CNT_W'(1);
        end else if (!w_accept && w_issue_any) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed testbench for alu_rs_scheduler with hand-computed expectations.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_type;
  logic [31:0] in_vj;
  logic [31:0] in_vk;
  logic [3:0]  in_qj;
  logic [3:0]  in_qk;
  logic        in_qj_busy;
  logic        in_qk_busy;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [3:0]  in_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        alu_valid;
  logic [5:0]  alu_type;
  logic [31:0] alu_vj;
  logic [31:0] alu_vk;
  logic [31:0] alu_imm;
  logic [31:0] alu_pc;
  logic [3:0]  alu_tag;

  int n_checks;
  int n_fail;

  alu_rs_scheduler #(
    .RS_SIZE (8),
    .TYPE_W  (6),
    .TAG_W   (4),
    .DATA_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_vj      (in_vj),
    .in_vk      (in_vk),
    .in_qj      (in_qj),
    .in_qk      (in_qk),
    .in_qj_busy (in_qj_busy),
    .in_qk_busy (in_qk_busy),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .in_tag     (in_tag),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .alu_valid  (alu_valid),
    .alu_type   (alu_type),
    .alu_vj     (alu_vj),
    .alu_vk     (alu_vk),
    .alu_imm    (alu_imm),
    .alu_pc     (alu_pc),
    .alu_tag    (alu_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] t, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic qjb, input logic [3:0] qk,
                       input logic qkb, input logic [31:0] imm, input logic [3:0] tag);
    in_valid   = 1'b1;
    in_type    = t;
    in_vj      = vj;
    in_vk      = vk;
    in_qj      = qj;
    in_qj_busy = qjb;
    in_qk      = qk;
    in_qk_busy = qkb;
    in_imm     = imm;
    in_pc      = 32'h1000 + {28'd0, tag};
    in_tag     = tag;
  endtask

  task automatic broadcast(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  // Entry i waits on producer 8+i, except entry 0 on tag 0 and entries 1/3 share tag 9.
  task automatic fill_eight();
    logic [3:0] prod;
    for (int i = 0; i < 8; i++) begin
      prod = (i == 0) ? 4'd0 : (i == 3) ? 4'd9 : 4'(8 + i);
      offer(TY_ADD, 32'd0, 32'(i), prod, 1'b1, 4'd0, 1'b0, 32'd0, 4'(i));
      tick();
      if (i == 6) check("fill7_ready", {31'd0, in_ready}, 32'd1);
      if (i == 7) check("fill8_notready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_type = '0; in_vj = '0; in_vk = '0; in_qj = '0; in_qk = '0;
    in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_imm = '0; in_pc = '0; in_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;

    // 1: reset
    tick(); tick();
    check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_alu_tag", {28'd0, alu_tag}, 32'd0);
    check("rst_alu_vj", alu_vj, 32'd0);
    rst = 1'b1;
    tick();

    // 2: ready ADDI issues one cycle after accept; rdy low freezes outputs
    offer(TY_ADDI, 32'd5, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd3, 4'd2);
    tick();
    in_valid = 1'b0;
    check("addi_lat0", {31'd0, alu_valid}, 32'd0);
    tick();
    check("addi_valid", {31'd0, alu_valid}, 32'd1);
    check("addi_type", {26'd0, alu_type}, {26'd0, TY_ADDI});
    check("addi_vj", alu_vj, 32'd5);
    check("addi_imm", alu_imm, 32'd3);
    check("addi_tag", {28'd0, alu_tag}, 32'd2);
    check("addi_pc", alu_pc, 32'h1002);
    rdy = 1'b0;
    tick();
    check("freeze_valid", {31'd0, alu_valid}, 32'd1);
    check("freeze_tag", {28'd0, alu_tag}, 32'd2);
    rdy = 1'b1;
    tick();
    check("addi_drain", {31'd0, alu_valid}, 32'd0);

    // 3: ADD waits on tag 7, woken two cycles later
    offer(TY_ADD, 32'd0, 32'd2, 4'd7, 1'b1, 4'd0, 1'b0, 32'd0, 4'd3);
    tick();
    in_valid = 1'b0;
    tick();
    check("add_wait", {31'd0, alu_valid}, 32'd0);
    broadcast(4'd7, 32'h10);
    tick();
    cdb_valid = 1'b0;
    check("add_wake_edge", {31'd0, alu_valid}, 32'd0);
    tick();
    check("add_valid", {31'd0, alu_valid}, 32'd1);
    check("add_vj", alu_vj, 32'h10);
    check("add_vk", alu_vk, 32'd2);
    check("add_tag", {28'd0, alu_tag}, 32'd3);

    // 4: same-cycle CDB capture on dispatch
    offer(TY_SUB, 32'd1, 32'd0, 4'd0, 1'b0, 4'd4, 1'b1, 32'd0, 4'd5);
    broadcast(4'd4, 32'd9);
    tick();
    in_valid = 1'b0;
    cdb_valid = 1'b0;
    tick();
    check("byp_valid", {31'd0, alu_valid}, 32'd1);
    check("byp_vk", alu_vk, 32'd9);
    check("byp_type", {26'd0, alu_type}, {26'd0, TY_SUB});
    check("byp_tag", {28'd0, alu_tag}, 32'd5);

    // Non-calc dispatch must be dropped
    offer(TY_BEQ, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0, 4'd6);
    tick();
    in_valid = 1'b0;
    tick();
    check("noncalc_drop", {31'd0, alu_valid}, 32'd0);

    // 5: fill, then wake entries 1 and 3 together through shared tag 9
    fill_eight();
    check("fill_no_issue", {31'd0, alu_valid}, 32'd0);
    broadcast(4'd9, 32'h55);
    tick();
    cdb_valid = 1'b0;
    check("wake13_edge", {31'd0, alu_valid}, 32'd0);
    check("wake13_full", {31'd0, in_ready}, 32'd0);
    tick();
    check("iss1_valid", {31'd0, alu_valid}, 32'd1);
    check("iss1_tag", {28'd0, alu_tag}, 32'd1);
    check("iss1_vj", alu_vj, 32'h55);
    check("iss1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("iss3_valid", {31'd0, alu_valid}, 32'd1);
    check("iss3_tag", {28'd0, alu_tag}, 32'd3);
    check("iss3_vk", alu_vk, 32'd3);
    tick();
    check("iss_idle", {31'd0, alu_valid}, 32'd0);

    // Tag 0 is a legal producer tag
    broadcast(4'd0, 32'd7);
    tick();
    cdb_valid = 1'b0;
    tick();
    check("tag0_valid", {31'd0, alu_valid}, 32'd1);
    check("tag0_tag", {28'd0, alu_tag}, 32'd0);
    check("tag0_vj", alu_vj, 32'd7);

    // 6: flush with five entries and a ready dispatch in the same cycle
    flush = 1'b1;
    offer(TY_ADDI, 32'd1, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd1, 4'd9);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, alu_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush_dropped", {31'd0, alu_valid}, 32'd0);
    broadcast(4'd12, 32'd1);
    tick();
    cdb_valid = 1'b0;
    tick();
    check("flush_gone", {31'd0, alu_valid}, 32'd0);
    fill_eight();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
